// File: rtl/fft_pease_sample_deserializer.sv
// rtl/fft_pease_sample_deserializer.sv - serial sample to parallel frame front end of the Pease FFT (optional FFT_DESERIALIZER_DBUF_EN double buffering)
module fft_pease_sample_deserializer #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy
);

    localparam int CW = $clog2(N_SAMPLES);

    // FILL: output stage empty; FULL: output stage holds a frame awaiting the FFT
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          recv_fire;
    logic          send_fire;
    logic          fill_done;

    assign recv_fire = recv_val && recv_rdy;
    assign send_fire = send_val && send_rdy;
    assign fill_done = recv_fire && (count == CW'(N_SAMPLES - 1));

    // Fill position; wraps naturally to 0 after the last slot since N_SAMPLES is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (recv_fire) begin
            count <= count + CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

`ifdef FFT_DESERIALIZER_DBUF_EN

    logic [BIT_WIDTH-1:0] fill_buf [N_SAMPLES];
    logic                 fill_full;
    logic                 load_direct;
    logic                 load_parked;

    // Completed frame goes straight to the output when the output is free this cycle,
    // otherwise it is parked in the fill buffer until the pending frame is taken
    assign load_direct = fill_done && ((state == FILL) || send_fire);
    assign load_parked = fill_full && send_fire;

    // Next-state: output stays occupied whenever a new frame replaces the departing one
    always_comb begin
        state_next = state;
        case (state)
            FILL: if (fill_done) state_next = FULL;
            FULL: if (send_fire && !fill_done && !fill_full) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Outputs depend on registered state only
    always_comb begin
        recv_rdy = !fill_full;
        send_val = (state == FULL);
    end

    // Parked-frame flag: set when a fill completes behind an unsent frame, cleared when it moves out
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_full <= 1'b0;
        end else if (fill_done && (state == FULL) && !send_fire) begin
            fill_full <= 1'b1;
        end else if (load_parked) begin
            fill_full <= 1'b0;
        end
    end

    // Fill buffer write; contents are only meaningful once a frame completes
    always_ff @(posedge clk) begin
        if (recv_fire) begin
            fill_buf[count] <= recv_msg;
        end
    end

    // Output stage load; on a direct load the last sample bypasses the fill buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                send_msg[k] <= '0;
            end
        end else if (load_direct) begin
            for (int k = 0; k < N_SAMPLES - 1; k++) begin
                send_msg[k] <= fill_buf[k];
            end
            send_msg[N_SAMPLES-1] <= recv_msg;
        end else if (load_parked) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                send_msg[k] <= fill_buf[k];
            end
        end
    end

`else

    // Next-state: fill until the last slot is written, then hold the frame until taken
    always_comb begin
        state_next = state;
        case (state)
            FILL: if (fill_done) state_next = FULL;
            FULL: if (send_fire) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Outputs depend on registered state only
    always_comb begin
        recv_rdy = (state == FILL);
        send_val = (state == FULL);
    end

    // Samples land directly in the output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                send_msg[k] <= '0;
            end
        end else if (recv_fire) begin
            send_msg[count] <= recv_msg;
        end
    end

`endif

endmodule

// File: tb/tb_fft_pease_sample_deserializer.sv
// tb/tb_fft_pease_sample_deserializer.sv - scoreboard bench for fft_pease_sample_deserializer
module tb_fft_pease_sample_deserializer;

    localparam int BW = 32;
    localparam int N  = 8;
    localparam int FW = BW * N;

    logic          clk;
    logic          reset;
    logic [BW-1:0] recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [BW-1:0] send_msg [N];
    logic          send_val;
    logic          send_rdy;

    fft_pease_sample_deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    int            m_count = 0;
    bit            m_out_full = 0;
    bit            m_fill_full = 0;
    logic [BW-1:0] m_part [N];
    logic [FW-1:0] sb_q [$];
    int            frames_out = 0;
    bit            exp_rdy, exp_val, rf, sf, fd;

    task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_out();
        logic [FW-1:0] r;
        for (int k = 0; k < N; k++) r[k*BW +: BW] = send_msg[k];
        return r;
    endfunction

    function automatic logic [FW-1:0] pack_part();
        logic [FW-1:0] r;
        for (int k = 0; k < N; k++) r[k*BW +: BW] = m_part[k];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // model step: inputs and outputs are stable at the falling edge
    always @(negedge clk) begin
        if (reset) begin
            m_count     = 0;
            m_out_full  = 0;
            m_fill_full = 0;
            sb_q.delete();
        end else begin
            exp_val = m_out_full;
`ifdef FFT_DESERIALIZER_DBUF_EN
            exp_rdy = !m_fill_full;
`else
            exp_rdy = !m_out_full;
`endif
            check_eq("recv_rdy", recv_rdy, exp_rdy);
            check_eq("send_val", send_val, exp_val);
            rf = recv_val && exp_rdy;
            sf = send_rdy && exp_val;
            if (exp_val) begin
                if (sb_q.size() == 0) check_eq("sb_nonempty", sb_q.size(), 1);
                else check_eq("send_msg", pack_out(), sb_q[0]);
            end
            if (sf && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                frames_out++;
            end
            fd = 0;
            if (rf) begin
                m_part[m_count] = recv_msg;
                if (m_count == N - 1) begin
                    fd = 1;
                    sb_q.push_back(pack_part());
                    m_count = 0;
                end else begin
                    m_count++;
                end
            end
`ifdef FFT_DESERIALIZER_DBUF_EN
            if (fd && (!m_out_full || sf)) m_out_full = 1;
            else if (fd) m_fill_full = 1;
            else if (sf && m_fill_full) begin m_fill_full = 0; m_out_full = 1; end
            else if (sf) m_out_full = 0;
`else
            if (fd) m_out_full = 1;
            else if (sf) m_out_full = 0;
`endif
        end
    end

    int last_acc_cyc;

    task automatic push_sample(input logic [BW-1:0] d);
        bit acc;
        acc = 0;
        recv_val = 1;
        recv_msg = d;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = recv_rdy;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("accept", acc, 1);
        last_acc_cyc = cyc;
        recv_val = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, n_acc, first_cyc;
        bit acc;
        clk = 0; reset = 1; recv_val = 0; recv_msg = '0; send_rdy = 1;

        // T1 reset
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check_eq("reset_send_msg", pack_out(), '0);
        check_eq("reset_recv_rdy", recv_rdy, 1);
        check_eq("reset_send_val", send_val, 0);
        @(posedge clk); #1;

        // T2 single frame
        f0 = frames_out;
        for (int i = 0; i < N; i++) push_sample(BW'(i + 1));
        drain();
        check_eq("t2_frames", frames_out - f0, 1);

        // T3 backpressure
        f0 = frames_out;
        send_rdy = 0;
        for (int i = 0; i < N; i++) push_sample(32'h100 + BW'(i));
        n_acc = 0;
        for (int t = 0; t < 20; t++) begin
            recv_val = 1;
            recv_msg = 32'h200 + BW'(n_acc);
            @(negedge clk);
            acc = recv_rdy;
            @(posedge clk); #1;
            if (acc) n_acc++;
        end
        recv_val = 0;
`ifdef FFT_DESERIALIZER_DBUF_EN
        check_eq("t3_accepted", n_acc, 8);
`else
        check_eq("t3_accepted", n_acc, 0);
`endif
        send_rdy = 1;
        drain();
        check_eq("t3_frames", frames_out - f0, (n_acc == N) ? 2 : 1);

        // T4 bubbles
        f0 = frames_out;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) begin
                recv_val = 0;
                recv_msg = $urandom;
                @(posedge clk); #1;
            end
            push_sample(32'h8000_0001 + BW'(i));
        end
        drain();
        check_eq("t4_frames", frames_out - f0, 1);

        // T5 reset mid-frame
        f0 = frames_out;
        for (int i = 0; i < 5; i++) push_sample(32'h50 + BW'(i));
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        for (int i = 0; i < N; i++) push_sample(32'hA0 + BW'(i));
        drain();
        check_eq("t5_frames", frames_out - f0, 1);

        // T6 throughput
        f0 = frames_out;
        first_cyc = 0;
        for (int i = 0; i < 4 * N; i++) begin
            push_sample(32'hC000_0000 + BW'(i));
            if (i == 0) first_cyc = last_acc_cyc;
        end
        drain();
        check_eq("t6_frames", frames_out - f0, 4);
`ifdef FFT_DESERIALIZER_DBUF_EN
        check_eq("t6_span", last_acc_cyc - first_cyc + 1, 32);
`else
        check_eq("t6_span", last_acc_cyc - first_cyc + 1, 35);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
